// File: rtl/multicycle_control_unit_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: opcodes, ALU ops,
// FSM states, datapath selector codes and the opcode class used by the FSM.
package multicycle_control_unit_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_MOVE  = 6'b100000;
  localparam logic [5:0] OP_ADDI  = 6'b000010;
  localparam logic [5:0] OP_SUBI  = 6'b000011;
  localparam logic [5:0] OP_ANDI  = 6'b000100;
  localparam logic [5:0] OP_ORI   = 6'b000101;
  localparam logic [5:0] OP_SLTI  = 6'b000111;
  localparam logic [5:0] OP_LW    = 6'b001000;
  localparam logic [5:0] OP_LB    = 6'b001001;
  localparam logic [5:0] OP_SW    = 6'b010000;
  localparam logic [5:0] OP_SB    = 6'b010001;
  localparam logic [5:0] OP_BEQ   = 6'b100011;
  localparam logic [5:0] OP_BNE   = 6'b100111;
  localparam logic [5:0] OP_J     = 6'b111000;
  localparam logic [5:0] OP_JAL   = 6'b111001;

  // AND is all-zero so the reset value and the forced-low value coincide.
  localparam logic [2:0] ALUOP_AND   = 3'b000;
  localparam logic [2:0] ALUOP_OR    = 3'b001;
  localparam logic [2:0] ALUOP_ADD   = 3'b010;
  localparam logic [2:0] ALUOP_RTYPE = 3'b011;
  localparam logic [2:0] ALUOP_SUB   = 3'b110;
  localparam logic [2:0] ALUOP_LESS  = 3'b111;

  localparam logic [1:0] PCSRC_PC4  = 2'd0;
  localparam logic [1:0] PCSRC_BR   = 2'd1;
  localparam logic [1:0] PCSRC_JMP  = 2'd2;
  localparam logic [1:0] REGDST_RT  = 2'd0;
  localparam logic [1:0] REGDST_RD  = 2'd1;
  localparam logic [1:0] REGDST_RA  = 2'd2;
  localparam logic [1:0] M2R_ALU    = 2'd0;
  localparam logic [1:0] M2R_MEM    = 2'd1;
  localparam logic [1:0] M2R_PC4    = 2'd2;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    CLS_RTYPE, CLS_IMM, CLS_LOAD, CLS_STORE,
    CLS_BEQ, CLS_BNE, CLS_J, CLS_JAL, CLS_ILLEGAL
  } op_class_t;

endpackage

// File: rtl/multicycle_control_unit_opcode_classifier.sv
// Combinational opcode table: maps an opcode to its class, ALU op, byte flag
// and legality so the sequencing FSM never looks at raw opcodes.
module multicycle_control_unit_opcode_classifier
  import multicycle_control_unit_pkg::*;
#(
  parameter int OPCODE_W = 6,
  parameter int ALUOP_W  = 3
) (
  input  logic [OPCODE_W-1:0] i_opcode,
  output op_class_t           o_cls,
  output logic [ALUOP_W-1:0]  o_alu_op,
  output logic                o_is_byte,
  output logic                o_legal
);

  always_comb begin
    o_cls     = CLS_ILLEGAL;
    o_alu_op  = ALUOP_W'(ALUOP_AND);
    o_is_byte = 1'b0;
    case (i_opcode)
      OPCODE_W'(OP_RTYPE): begin o_cls = CLS_RTYPE; o_alu_op = ALUOP_W'(ALUOP_RTYPE); end
      OPCODE_W'(OP_MOVE):  begin o_cls = CLS_IMM;   o_alu_op = ALUOP_W'(ALUOP_ADD);   end
      OPCODE_W'(OP_ADDI):  begin o_cls = CLS_IMM;   o_alu_op = ALUOP_W'(ALUOP_ADD);   end
      OPCODE_W'(OP_SUBI):  begin o_cls = CLS_IMM;   o_alu_op = ALUOP_W'(ALUOP_SUB);   end
      OPCODE_W'(OP_ANDI):  begin o_cls = CLS_IMM;   o_alu_op = ALUOP_W'(ALUOP_AND);   end
      OPCODE_W'(OP_ORI):   begin o_cls = CLS_IMM;   o_alu_op = ALUOP_W'(ALUOP_OR);    end
      OPCODE_W'(OP_SLTI):  begin o_cls = CLS_IMM;   o_alu_op = ALUOP_W'(ALUOP_LESS);  end
      OPCODE_W'(OP_LW):    begin o_cls = CLS_LOAD;  o_alu_op = ALUOP_W'(ALUOP_ADD);   end
      OPCODE_W'(OP_LB):    begin o_cls = CLS_LOAD;  o_alu_op = ALUOP_W'(ALUOP_ADD); o_is_byte = 1'b1; end
      OPCODE_W'(OP_SW):    begin o_cls = CLS_STORE; o_alu_op = ALUOP_W'(ALUOP_ADD);   end
      OPCODE_W'(OP_SB):    begin o_cls = CLS_STORE; o_alu_op = ALUOP_W'(ALUOP_ADD); o_is_byte = 1'b1; end
      OPCODE_W'(OP_BEQ):   begin o_cls = CLS_BEQ;   o_alu_op = ALUOP_W'(ALUOP_SUB);   end
      OPCODE_W'(OP_BNE):   begin o_cls = CLS_BNE;   o_alu_op = ALUOP_W'(ALUOP_SUB);   end
      OPCODE_W'(OP_J):     o_cls = CLS_J;
      OPCODE_W'(OP_JAL):   o_cls = CLS_JAL;
      default:             o_cls = CLS_ILLEGAL;
    endcase
  end

  assign o_legal = (o_cls != CLS_ILLEGAL);

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS control FSM (FETCH/DECODE/EXEC/MEM/WB/TRAP) driving the shared
// datapath; memory strobes hold until memReady, illegal opcodes park in TRAP.
module multicycle_control_unit
  import multicycle_control_unit_pkg::*;
#(
  parameter int OPCODE_W = 6,
  parameter int ALUOP_W  = 3,
  parameter int CNT_W    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                memReady,
  output logic                pcWrite,
  output logic [1:0]          pcSrc,
  output logic                irWrite,
  output logic                memRead,
  output logic                memWrite,
  output logic                byteEn,
  output logic                regWrite,
  output logic [1:0]          regDst,
  output logic [1:0]          memToReg,
  output logic                ALUsrc,
  output logic [ALUOP_W-1:0]  ALUop,
  output logic                illegalOp,
  output logic [2:0]          state,
  output logic [CNT_W-1:0]    retired
);

  state_t              r_state;
  logic [OPCODE_W-1:0] r_op_reg;
  logic [CNT_W-1:0]    r_retired;

  logic [OPCODE_W-1:0] w_cls_op;
  op_class_t           w_cls;
  logic [ALUOP_W-1:0]  w_alu_op;
  logic                w_is_byte;
  logic                w_legal;

  // DECODE classifies the live IR field; later states use the latched copy.
  assign w_cls_op = (r_state == ST_DECODE) ? opcode : r_op_reg;

  multicycle_control_unit_opcode_classifier #(
    .OPCODE_W (OPCODE_W),
    .ALUOP_W  (ALUOP_W)
  ) u_classifier (
    .i_opcode  (w_cls_op),
    .o_cls     (w_cls),
    .o_alu_op  (w_alu_op),
    .o_is_byte (w_is_byte),
    .o_legal   (w_legal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_FETCH;
      r_op_reg  <= '0;
      r_retired <= '0;
    end else begin
      case (r_state)
        ST_FETCH:  if (memReady) r_state <= ST_DECODE;
        ST_DECODE: begin
          r_op_reg <= opcode;
          r_state  <= w_legal ? ST_EXEC : ST_TRAP;
        end
        ST_EXEC: begin
          case (w_cls)
            CLS_RTYPE, CLS_IMM:   r_state <= ST_WB;
            CLS_LOAD, CLS_STORE:  r_state <= ST_MEM;
            default: begin
              r_state   <= ST_FETCH;
              r_retired <= r_retired + CNT_W'(1);
            end
          endcase
        end
        ST_MEM: begin
          if (memReady) begin
            if (w_cls == CLS_LOAD) begin
              r_state <= ST_WB;
            end else begin
              r_state   <= ST_FETCH;
              r_retired <= r_retired + CNT_W'(1);
            end
          end
        end
        ST_WB: begin
          r_state   <= ST_FETCH;
          r_retired <= r_retired + CNT_W'(1);
        end
        default: r_state <= ST_TRAP;
      endcase
    end
  end

  always_comb begin
    pcWrite   = 1'b0;
    pcSrc     = PCSRC_PC4;
    irWrite   = 1'b0;
    memRead   = 1'b0;
    memWrite  = 1'b0;
    byteEn    = 1'b0;
    regWrite  = 1'b0;
    regDst    = REGDST_RT;
    memToReg  = M2R_ALU;
    ALUsrc    = 1'b0;
    ALUop     = ALUOP_W'(ALUOP_AND);
    illegalOp = 1'b0;
    state     = 3'd0;
    retired   = '0;
    if (!rst) begin
      state     = r_state;
      retired   = r_retired;
      illegalOp = (r_state == ST_TRAP);
      case (r_state)
        ST_FETCH: begin
          memRead = 1'b1;
          irWrite = memReady;
          pcWrite = memReady;
        end
        ST_EXEC: begin
          ALUop  = w_alu_op;
          ALUsrc = (w_cls == CLS_IMM) || (w_cls == CLS_LOAD) || (w_cls == CLS_STORE);
          case (w_cls)
            CLS_BEQ: begin pcSrc = PCSRC_BR; pcWrite = zero;  end
            CLS_BNE: begin pcSrc = PCSRC_BR; pcWrite = !zero; end
            CLS_J:   begin pcSrc = PCSRC_JMP; pcWrite = 1'b1; end
            CLS_JAL: begin
              pcSrc    = PCSRC_JMP;
              pcWrite  = 1'b1;
              regWrite = 1'b1;
              regDst   = REGDST_RA;
              memToReg = M2R_PC4;
            end
            default: ;
          endcase
        end
        ST_MEM: begin
          memRead  = (w_cls == CLS_LOAD);
          memWrite = (w_cls == CLS_STORE);
          byteEn   = w_is_byte;
        end
        ST_WB: begin
          regWrite = 1'b1;
          regDst   = (w_cls == CLS_RTYPE) ? REGDST_RD : REGDST_RT;
          memToReg = (w_cls == CLS_LOAD) ? M2R_MEM : M2R_ALU;
        end
        default: ;
      endcase
    end
  end

endmodule
